// File: rtl/aska_npg_pkg.sv
// Shared definitions for the ASKA neural pulse generator configuration front-end.
// Holds register widths, the host address map, CTRL bit positions, reset values,
// the commit FSM state encoding and a small byte-lane insert helper.
package aska_npg_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  localparam int unsigned AMP_W  = 6;
  localparam int unsigned FREQ_W = 12;
  localparam int unsigned PH_W   = 3;
  localparam int unsigned RAMP_W = 6;
  localparam int unsigned RF_W   = 10;
  localparam int unsigned ON_W   = 8;
  localparam int unsigned OFF_W  = 10;
  localparam int unsigned EL_W   = 32;

  // Number of quotient bits produced by the divider (one per cycle).
  localparam int unsigned DIV_STEPS = RF_W;

  localparam int unsigned FREQ_RST_DEF  = 400;
  localparam int unsigned PHASE_RST_DEF = 1;

  localparam logic [ADDR_W-1:0] ADDR_AMP     = 5'd0;
  localparam logic [ADDR_W-1:0] ADDR_FREQ_LO = 5'd1;
  localparam logic [ADDR_W-1:0] ADDR_FREQ_HI = 5'd2;
  localparam logic [ADDR_W-1:0] ADDR_PHASE   = 5'd3;
  localparam logic [ADDR_W-1:0] ADDR_RAMP    = 5'd4;
  localparam logic [ADDR_W-1:0] ADDR_ON      = 5'd5;
  localparam logic [ADDR_W-1:0] ADDR_OFF_LO  = 5'd6;
  localparam logic [ADDR_W-1:0] ADDR_OFF_HI  = 5'd7;
  localparam logic [ADDR_W-1:0] ADDR_EL1_B0  = 5'd8;
  localparam logic [ADDR_W-1:0] ADDR_EL2_B0  = 5'd12;
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 5'd16;

  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_COMMIT  = 1;
  localparam int unsigned CTRL_CLR_ERR = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDiv  = 2'd1,
    StWait = 2'd2
  } cfg_state_e;

  // Replace byte lane idx of a 32-bit word.
  function automatic logic [EL_W-1:0] set_byte(input logic [EL_W-1:0] word,
                                                input logic [1:0]      idx,
                                                input logic [7:0]      b);
    logic [EL_W-1:0] r;
    r = word;
    r[8*int'(idx) +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/aska_npg_cfg_if.sv
// Host byte-write bus into the configuration front-end.
//   wr_en/addr/wdata : one-cycle byte write from the SPI/UART bridge (host -> cfg)
//   wr_ready/busy    : commit status (cfg -> host)
//   cmd_err          : sticky dropped-write flag (cfg -> host)
interface aska_npg_cfg_if;
  import aska_npg_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wr_ready;
  logic              busy;
  logic              cmd_err;

  modport master (
    output wr_en, addr, wdata,
    input  wr_ready, busy, cmd_err
  );

  modport slave (
    input  wr_en, addr, wdata,
    output wr_ready, busy, cmd_err
  );
endinterface

// File: rtl/aska_npg_rdiv.sv
// 10-bit by 6-bit restoring divider, one quotient bit per cycle.
//   start    : latch operands and begin (ignored mid-run only by the caller)
//   dividend : 10-bit numerator
//   divisor  : 6-bit denominator; zero yields quotient 0 after the full run
//   done     : high during the cycle whose edge produces the last quotient bit
//   quotient : valid from the cycle after done until the next start
module aska_npg_rdiv
  import aska_npg_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [RF_W-1:0]   dividend,
  input  logic [RAMP_W-1:0] divisor,
  output logic              done,
  output logic [RF_W-1:0]   quotient
);

  localparam logic [3:0] LastStep = 4'(DIV_STEPS - 1);

  logic              run_q;
  logic [3:0]        cnt_q;
  logic [RF_W-1:0]   dvd_q;
  logic [RAMP_W-1:0] dvs_q;
  logic [RAMP_W-1:0] rem_q;
  logic [RF_W-1:0]   quo_q;
  logic              zero_q;

  logic [RAMP_W:0]   trial;
  logic              ge;
  logic [RAMP_W:0]   rem_next;

  always_comb begin
    trial    = {rem_q, dvd_q[RF_W-1]};
    ge       = (trial >= {1'b0, dvs_q});
    rem_next = ge ? (trial - {1'b0, dvs_q}) : trial;
  end

  assign done     = run_q && (cnt_q == LastStep);
  assign quotient = zero_q ? '0 : quo_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      zero_q <= 1'b0;
    end else if (start) begin
      run_q  <= 1'b1;
      cnt_q  <= '0;
      dvd_q  <= dividend;
      dvs_q  <= divisor;
      rem_q  <= '0;
      quo_q  <= '0;
      zero_q <= (divisor == '0);
    end else if (run_q) begin
      dvd_q <= {dvd_q[RF_W-2:0], 1'b0};
      // Remainder is always below the divisor, so it fits in RAMP_W bits.
      rem_q <= rem_next[RAMP_W-1:0];
      quo_q <= {quo_q[RF_W-2:0], ge};
      cnt_q <= cnt_q + 4'd1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/aska_npg_cfg.sv
// Configuration front-end for aska_npg.
// Host byte writes land in shadow registers; a CTRL commit computes
// ramp_factor = (amplitude*16)/ramp and then copies the whole shadow set into
// the active outputs on a single edge with pulse_active low.
//   clk, resetn      : clock, asynchronous active-low reset
//   bus (slave)      : host byte-write bus with wr_ready/busy/cmd_err status
//   pulse_active     : from aska_npg, defers the active update while high
//   amplitude..electrode2, ramp_factor : active parameter set to aska_npg
//   enable           : direct npg enable from CTRL bit0, not shadowed
module aska_npg_cfg
  import aska_npg_pkg::*;
#(
  parameter int unsigned FREQ_RST  = FREQ_RST_DEF,
  parameter int unsigned PHASE_RST = PHASE_RST_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  aska_npg_cfg_if.slave     bus,
  input  logic              pulse_active,
  output logic [AMP_W-1:0]  amplitude,
  output logic [FREQ_W-1:0] freq,
  output logic [PH_W-1:0]   phaseDuration,
  output logic [RAMP_W-1:0] ramp,
  output logic [RF_W-1:0]   ramp_factor,
  output logic [ON_W-1:0]   ON_time,
  output logic [OFF_W-1:0]  OFF_time,
  output logic [EL_W-1:0]   electrode1,
  output logic [EL_W-1:0]   electrode2,
  output logic              enable
);

  localparam logic [FREQ_W-1:0] FreqRstV  = FREQ_W'(FREQ_RST);
  localparam logic [PH_W-1:0]   PhaseRstV = PH_W'(PHASE_RST);

  cfg_state_e state_q, state_d;

  logic busy, div_start, load_active, div_done;
  logic [RF_W-1:0] quotient;

  logic wr_shadow, wr_ctrl, commit_req, err_set, err_clr;
  logic cmd_err_q, cmd_err_d;
  logic enable_q;

  logic [AMP_W-1:0]  sh_amp_q,  sh_amp_d,  act_amp_q;
  logic [FREQ_W-1:0] sh_freq_q, sh_freq_d, act_freq_q;
  logic [PH_W-1:0]   sh_ph_q,   sh_ph_d,   act_ph_q;
  logic [RAMP_W-1:0] sh_ramp_q, sh_ramp_d, act_ramp_q;
  logic [ON_W-1:0]   sh_on_q,   sh_on_d,   act_on_q;
  logic [OFF_W-1:0]  sh_off_q,  sh_off_d,  act_off_q;
  logic [EL_W-1:0]   sh_el1_q,  sh_el1_d,  act_el1_q;
  logic [EL_W-1:0]   sh_el2_q,  sh_el2_d,  act_el2_q;
  logic [RF_W-1:0]   act_rf_q;

  // Host decode. Addresses 17-31 fall through and are ignored.
  assign wr_shadow  = bus.wr_en && !bus.addr[4];
  assign wr_ctrl    = bus.wr_en && (bus.addr == ADDR_CTRL);
  assign commit_req = wr_ctrl && bus.wdata[CTRL_COMMIT];

  // FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (commit_req)    state_d = StDiv;
      StDiv:   if (div_done)      state_d = StWait;
      StWait:  if (!pulse_active) state_d = StIdle;
      default:                    state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy         = (state_q != StIdle);
    bus.wr_ready = (state_q == StIdle);
    div_start    = (state_q == StIdle) && commit_req;
    load_active  = (state_q == StWait) && !pulse_active;
  end

  assign bus.busy = busy;

  aska_npg_rdiv u_rdiv (
    .clk      (clk),
    .resetn   (resetn),
    .start    (div_start),
    .dividend ({sh_amp_q, 4'b0000}),
    .divisor  (sh_ramp_q),
    .done     (div_done),
    .quotient (quotient)
  );

  // Sticky error: a new drop wins over a same-cycle clear.
  always_comb begin
    err_set   = busy && (wr_shadow || commit_req);
    err_clr   = wr_ctrl && bus.wdata[CTRL_CLR_ERR];
    cmd_err_d = cmd_err_q;
    if (err_set)      cmd_err_d = 1'b1;
    else if (err_clr) cmd_err_d = 1'b0;
  end

  assign bus.cmd_err = cmd_err_q;

  // Shadow next-state; frozen while busy so the pending commit stays coherent.
  always_comb begin
    sh_amp_d  = sh_amp_q;
    sh_freq_d = sh_freq_q;
    sh_ph_d   = sh_ph_q;
    sh_ramp_d = sh_ramp_q;
    sh_on_d   = sh_on_q;
    sh_off_d  = sh_off_q;
    sh_el1_d  = sh_el1_q;
    sh_el2_d  = sh_el2_q;
    if (wr_shadow && !busy) begin
      case (bus.addr)
        ADDR_AMP:     sh_amp_d        = bus.wdata[AMP_W-1:0];
        ADDR_FREQ_LO: sh_freq_d[7:0]  = bus.wdata;
        ADDR_FREQ_HI: sh_freq_d[11:8] = bus.wdata[3:0];
        ADDR_PHASE:   sh_ph_d         = bus.wdata[PH_W-1:0];
        ADDR_RAMP:    sh_ramp_d       = bus.wdata[RAMP_W-1:0];
        ADDR_ON:      sh_on_d         = bus.wdata;
        ADDR_OFF_LO:  sh_off_d[7:0]   = bus.wdata;
        ADDR_OFF_HI:  sh_off_d[9:8]   = bus.wdata[1:0];
        default: begin
          if (bus.addr[4:2] == ADDR_EL1_B0[4:2]) begin
            sh_el1_d = set_byte(sh_el1_q, bus.addr[1:0], bus.wdata);
          end else if (bus.addr[4:2] == ADDR_EL2_B0[4:2]) begin
            sh_el2_d = set_byte(sh_el2_q, bus.addr[1:0], bus.wdata);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_amp_q  <= '0;
      sh_freq_q <= FreqRstV;
      sh_ph_q   <= PhaseRstV;
      sh_ramp_q <= '0;
      sh_on_q   <= '0;
      sh_off_q  <= '0;
      sh_el1_q  <= '0;
      sh_el2_q  <= '0;
      cmd_err_q <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      sh_amp_q  <= sh_amp_d;
      sh_freq_q <= sh_freq_d;
      sh_ph_q   <= sh_ph_d;
      sh_ramp_q <= sh_ramp_d;
      sh_on_q   <= sh_on_d;
      sh_off_q  <= sh_off_d;
      sh_el1_q  <= sh_el1_d;
      sh_el2_q  <= sh_el2_d;
      cmd_err_q <= cmd_err_d;
      if (wr_ctrl) enable_q <= bus.wdata[CTRL_ENABLE];
    end
  end

  // Active set: every field and ramp_factor load on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      act_amp_q  <= '0;
      act_freq_q <= FreqRstV;
      act_ph_q   <= PhaseRstV;
      act_ramp_q <= '0;
      act_on_q   <= '0;
      act_off_q  <= '0;
      act_el1_q  <= '0;
      act_el2_q  <= '0;
      act_rf_q   <= '0;
    end else if (load_active) begin
      act_amp_q  <= sh_amp_q;
      act_freq_q <= sh_freq_q;
      act_ph_q   <= sh_ph_q;
      act_ramp_q <= sh_ramp_q;
      act_on_q   <= sh_on_q;
      act_off_q  <= sh_off_q;
      act_el1_q  <= sh_el1_q;
      act_el2_q  <= sh_el2_q;
      act_rf_q   <= quotient;
    end
  end

  assign amplitude     = act_amp_q;
  assign freq          = act_freq_q;
  assign phaseDuration = act_ph_q;
  assign ramp          = act_ramp_q;
  assign ramp_factor   = act_rf_q;
  assign ON_time       = act_on_q;
  assign OFF_time      = act_off_q;
  assign electrode1    = act_el1_q;
  assign electrode2    = act_el2_q;
  assign enable        = enable_q;

endmodule

// File: tb/tb_aska_npg_cfg.sv
module tb_aska_npg_cfg;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic pulse_active = 1'b0;

  logic [5:0]  amplitude;
  logic [11:0] freq;
  logic [2:0]  phaseDuration;
  logic [5:0]  ramp;
  logic [9:0]  ramp_factor;
  logic [7:0]  ON_time;
  logic [9:0]  OFF_time;
  logic [31:0] electrode1;
  logic [31:0] electrode2;
  logic        enable;

  aska_npg_cfg_if bus ();

  aska_npg_cfg dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus),
    .pulse_active  (pulse_active),
    .amplitude     (amplitude),
    .freq          (freq),
    .phaseDuration (phaseDuration),
    .ramp          (ramp),
    .ramp_factor   (ramp_factor),
    .ON_time       (ON_time),
    .OFF_time      (OFF_time),
    .electrode1    (electrode1),
    .electrode2    (electrode2),
    .enable        (enable)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the host-visible byte register file plus committed state.
  logic [7:0]   sh [16];
  logic [118:0] exp_act;
  logic         m_busy;
  logic [118:0] dut_vec;

  assign dut_vec = {amplitude, freq, phaseDuration, ramp, ramp_factor, ON_time, OFF_time,
                    electrode1, electrode2};

  // Expected active set if the current byte file were committed.
  function automatic logic [118:0] calc_vec();
    int amp, rmp, rf;
    amp = int'(sh[0][5:0]);
    rmp = int'(sh[4][5:0]);
    rf  = (rmp == 0) ? 0 : (amp * 16) / rmp;
    return {sh[0][5:0], sh[2][3:0], sh[1], sh[3][2:0], sh[4][5:0], 10'(rf), sh[5],
            sh[7][1:0], sh[6], sh[11], sh[10], sh[9], sh[8], sh[15], sh[14], sh[13], sh[12]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) sh[i] = 8'h00;
    sh[1] = 8'h90;  // 400 = 0x190
    sh[2] = 8'h01;
    sh[3] = 8'h01;
    m_busy = 1'b0;
    exp_act = calc_vec();
  endtask

  // Called at a negedge; returns one cycle later, after the sampling edge.
  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (a < 5'd16 && !m_busy) sh[a[3:0]] = d;
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while (bus.busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (bus.busy) begin
      n_errors++;
      $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", tag, bus.busy, guard);
    end
  endtask

  task automatic test_reset();
    n_checks++; if (amplitude !== 6'd0) begin n_errors++;
      $display("FAIL rst_amp: got %0d want 0", amplitude); end
    n_checks++; if (freq !== 12'd400) begin n_errors++;
      $display("FAIL rst_freq: got %0d want 400", freq); end
    n_checks++; if (phaseDuration !== 3'd1) begin n_errors++;
      $display("FAIL rst_phase: got %0d want 1", phaseDuration); end
    n_checks++; if (ramp_factor !== 10'd0) begin n_errors++;
      $display("FAIL rst_rf: got %0d want 0", ramp_factor); end
    n_checks++; if (dut_vec !== exp_act) begin n_errors++;
      $display("FAIL rst_all: got %h want %h", dut_vec, exp_act); end
    n_checks++; if ({enable, bus.busy, bus.wr_ready, bus.cmd_err} !== 4'b0010) begin n_errors++;
      $display("FAIL rst_status: got en/busy/rdy/err %b want 0010",
               {enable, bus.busy, bus.wr_ready, bus.cmd_err}); end
  endtask

  task automatic test_basic_commit();
    logic [118:0] old;
    bus_write(5'd0, 8'd50);
    bus_write(5'd4, 8'd50);
    bus_write(5'd1, 8'h90);
    bus_write(5'd2, 8'h01);
    old = exp_act;
    bus_write(5'd16, 8'h02);  // commit sampled at E0
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 11) begin
        n_checks++; if (!bus.busy || bus.wr_ready || dut_vec !== old) begin n_errors++;
          $display("FAIL basic_hold_e%0d: busy=%b rdy=%b vec=%h want busy=1 rdy=0 vec=%h",
                   k, bus.busy, bus.wr_ready, dut_vec, old); end
      end else begin
        exp_act = calc_vec();
        n_checks++; if (bus.busy || dut_vec !== exp_act) begin n_errors++;
          $display("FAIL basic_e11: busy=%b vec=%h want busy=0 vec=%h",
                   bus.busy, dut_vec, exp_act); end
        n_checks++; if (ramp_factor !== 10'd16) begin n_errors++;
          $display("FAIL basic_rf: got %0d want 16", ramp_factor); end
      end
    end
  endtask

  task automatic test_divider_corners();
    int amps [4] = '{63, 1, 37, 20};
    int rmps [4] = '{1, 50, 7, 0};
    int rfs  [4] = '{1008, 0, 84, 0};
    for (int i = 0; i < 10; i++) begin
      int a, r;
      a = (i < 4) ? amps[i] : int'($urandom_range(0, 63));
      r = (i < 4) ? rmps[i] : int'($urandom_range(0, 63));
      bus_write(5'd0, 8'(a));
      bus_write(5'd4, 8'(r));
      bus_write(5'd16, 8'h02);
      wait_idle("div");
      exp_act = calc_vec();
      n_checks++; if (dut_vec !== exp_act) begin n_errors++;
        $display("FAIL div_%0d_%0d: vec=%h want %h", a, r, dut_vec, exp_act); end
      if (i < 4) begin
        n_checks++; if (ramp_factor !== 10'(rfs[i])) begin n_errors++;
          $display("FAIL div_rf_%0d_%0d: got %0d want %0d", a, r, ramp_factor, rfs[i]); end
      end
    end
  endtask

  task automatic test_pulse_defer();
    logic [118:0] old;
    for (int a = 0; a < 16; a++) bus_write(5'(a), 8'($urandom));
    old = exp_act;
    bus_write(5'd16, 8'h02);
    for (int k = 1; k <= 25; k++) begin
      pulse_active = (k >= 5 && k <= 24);
      @(negedge clk);
      if (k < 25) begin
        n_checks++; if (!bus.busy || dut_vec !== old) begin n_errors++;
          $display("FAIL defer_hold_e%0d: busy=%b vec=%h want busy=1 vec=%h",
                   k, bus.busy, dut_vec, old); end
      end else begin
        exp_act = calc_vec();
        n_checks++; if (bus.busy || dut_vec !== exp_act) begin n_errors++;
          $display("FAIL defer_e25: busy=%b vec=%h want busy=0 vec=%h",
                   bus.busy, dut_vec, exp_act); end
      end
    end
    pulse_active = 1'b0;
  endtask

  task automatic test_busy_reject();
    logic [118:0] old;
    bus_write(5'd0, 8'd5);
    bus_write(5'd4, 8'd3);
    bus_write(5'd16, 8'h02);
    m_busy = 1'b1;
    bus_write(5'd0, 8'd10);
    n_checks++; if (bus.cmd_err !== 1'b1) begin n_errors++;
      $display("FAIL busy_shadow_err: cmd_err=%b want 1", bus.cmd_err); end
    bus_write(5'd16, 8'h04);
    n_checks++; if (bus.cmd_err !== 1'b0) begin n_errors++;
      $display("FAIL busy_clr: cmd_err=%b want 0", bus.cmd_err); end
    bus_write(5'd16, 8'h06);  // dropped commit and clear together
    n_checks++; if (bus.cmd_err !== 1'b1) begin n_errors++;
      $display("FAIL busy_set_wins: cmd_err=%b want 1", bus.cmd_err); end
    bus_write(5'd16, 8'h05);
    n_checks++; if (enable !== 1'b1 || bus.cmd_err !== 1'b0 || !bus.busy) begin n_errors++;
      $display("FAIL busy_enable: en=%b err=%b busy=%b want 1 0 1",
               enable, bus.cmd_err, bus.busy); end
    bus_write(5'd16, 8'h00);
    n_checks++; if (enable !== 1'b0 || bus.cmd_err !== 1'b0) begin n_errors++;
      $display("FAIL busy_disable: en=%b err=%b want 0 0", enable, bus.cmd_err); end
    wait_idle("busy");
    m_busy = 1'b0;
    exp_act = calc_vec();
    n_checks++; if (dut_vec !== exp_act || amplitude !== 6'd5) begin n_errors++;
      $display("FAIL busy_commit: vec=%h amp=%0d want %h amp=5", dut_vec, amplitude, exp_act); end
    old = exp_act;
    bus_write(5'd20, 8'hFF);
    bus_write(5'd31, 8'h02);
    repeat (12) @(negedge clk);
    n_checks++; if (dut_vec !== old || bus.cmd_err !== 1'b0 || bus.busy) begin n_errors++;
      $display("FAIL unmapped: vec=%h err=%b busy=%b want %h 0 0",
               dut_vec, bus.cmd_err, bus.busy, old); end
  endtask

  task automatic test_electrode_reset();
    bus_write(5'd8,  8'hEF);
    bus_write(5'd9,  8'hBE);
    bus_write(5'd10, 8'hAD);
    bus_write(5'd11, 8'hDE);
    bus_write(5'd12, 8'h11);
    bus_write(5'd15, 8'h44);
    bus_write(5'd16, 8'h02);
    wait_idle("el");
    exp_act = calc_vec();
    n_checks++; if (electrode1 !== 32'hDEADBEEF) begin n_errors++;
      $display("FAIL el1: got %h want deadbeef", electrode1); end
    n_checks++; if (dut_vec !== exp_act) begin n_errors++;
      $display("FAIL el_all: got %h want %h", dut_vec, exp_act); end
    bus_write(5'd0, 8'd9);
    bus_write(5'd16, 8'h03);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    model_reset();
    n_checks++; if (dut_vec !== exp_act || bus.busy !== 1'b0 || enable !== 1'b0) begin
      n_errors++;
      $display("FAIL abort: vec=%h busy=%b en=%b want %h 0 0",
               dut_vec, bus.busy, enable, exp_act); end
    @(negedge clk);
    resetn = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++; if (dut_vec !== exp_act || bus.wr_ready !== 1'b1) begin n_errors++;
      $display("FAIL abort_after: vec=%h rdy=%b want %h 1", dut_vec, bus.wr_ready, exp_act); end
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic_commit();
    test_divider_corners();
    test_pulse_defer();
    test_busy_reject();
    test_electrode_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
